// File: rtl/uart_block_tx.sv
// Serializes one block of BYTES_PER_BLOCK bytes onto a UART line as back-to-back 8N1 frames.
// The most significant byte goes first, LSB first within each byte, and DONE pulses when the last stop bit ends.
module uart_block_tx #(
    parameter int CLOCKS_PER_BIT  = 2604,
    parameter int BYTES_PER_BLOCK = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [8*BYTES_PER_BLOCK-1:0] block_in,
    input  logic                         block_valid,
    output logic                         block_ready,
    output logic                         txd,
    output logic                         busy,
    output logic                         done
);

    localparam int BLOCK_W = 8 * BYTES_PER_BLOCK;
    localparam int BYTE_W  = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam logic [11:0]       LAST_TICK = 12'(CLOCKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [11:0]          bit_cnt, bit_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [BYTE_W-1:0]    byte_idx, byte_idx_n;
    logic [BLOCK_W-1:0]   shreg, shreg_n;
    logic                 txd_n;
    logic                 done_n;
    logic                 bit_end;
    logic [7:0]           cur_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            shreg    <= shreg_n;
            txd      <= txd_n;
            done     <= done_n;
        end
    end

    // TXD is registered, so the line level is derived from the next-state values.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        done_n     = 1'b0;
        txd_n      = 1'b1;
        cur_byte   = '0;
        bit_end    = (bit_cnt == LAST_TICK);

        case (state)
            IDLE: begin
                if (block_valid) begin
                    state_n    = START;
                    shreg_n    = block_in;
                    bit_cnt_n  = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 12'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 12'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        // The next byte always sits in the top eight bits of the register.
                        shreg_n    = shreg << 8;
                        byte_idx_n = byte_idx + BYTE_W'(1);
                        state_n    = START;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 12'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        cur_byte = shreg_n[BLOCK_W-1 -: 8];
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = cur_byte[bit_idx_n];
            default: txd_n = 1'b1;
        endcase
    end

    assign block_ready = (state == IDLE);
    assign busy        = ~block_ready;

endmodule

// File: tb/tb_uart_block_tx.sv
// Self-checking bench for uart_block_tx with CLOCKS_PER_BIT=4: frame table, corner sequences and random blocks
// compared against a per-cycle line model computed directly from the UART framing rules.
module tb_uart_block_tx;

    localparam int CPB       = 4;
    localparam int NBYTES    = 16;
    localparam int BLOCK_CYC = 10 * NBYTES * CPB;

    logic         clk;
    logic         reset;
    logic [127:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic         txd;
    logic         busy;
    logic         done;

    int checks;
    int errors;
    int cycle;
    int last_accept;
    logic [9:0] cap_frames [NBYTES];

    typedef struct {
        int         byte_n;
        logic [9:0] frame;
    } frame_vec_t;

    frame_vec_t tbl [5];

    uart_block_tx #(
        .CLOCKS_PER_BIT (CPB),
        .BYTES_PER_BLOCK(NBYTES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .block_in   (block_in),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Line level k cycles after the accepting edge, straight from the 8N1 framing rules.
    function automatic logic model_txd(input logic [127:0] blk, input int k);
        int b;
        int n;
        int p;
        b = k / CPB;
        n = b / 10;
        p = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return blk[120 - 8 * n + (p - 1)];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads one block, follows it to the end-of-block edge and checks the line cycle by cycle.
    task automatic applyStimulus(input logic [127:0] blk, input bit disturb, input bit keep_valid);
        int         wave_bad;
        int         ready_bad;
        int         done_bad;
        int         framing_bad;
        logic [127:0] recon;
        int         b;
        int         n;
        int         p;
        wave_bad    = 0;
        ready_bad   = 0;
        done_bad    = 0;
        framing_bad = 0;
        recon       = '0;
        block_in    = blk;
        block_valid = 1'b1;
        checkOutput("ready_before_accept", block_ready, 1);
        tick();
        last_accept = cycle;
        for (int k = 0; k < BLOCK_CYC; k++) begin
            if (txd !== model_txd(blk, k)) wave_bad++;
            if (block_ready !== 1'b0 || busy !== 1'b1) ready_bad++;
            if (done !== 1'b0) done_bad++;
            if (k % CPB == CPB / 2) begin
                b = k / CPB;
                n = b / 10;
                p = b % 10;
                cap_frames[n][9 - p] = txd;
                if (p == 0 && txd !== 1'b0) framing_bad++;
                if (p == 9 && txd !== 1'b1) framing_bad++;
                if (p >= 1 && p <= 8) recon[120 - 8 * n + (p - 1)] = txd;
            end
            if (k == 0 && !keep_valid) block_valid = 1'b0;
            if (disturb) begin
                block_in    = {$urandom, $urandom, $urandom, $urandom};
                block_valid = 1'($urandom_range(0, 1));
            end
            tick();
        end
        checkOutput("waveform_mismatch_cycles", wave_bad, 0);
        checkOutput("ready_low_while_busy_violations", ready_bad, 0);
        checkOutput("early_done_cycles", done_bad, 0);
        checkOutput("framing_errors", framing_bad, 0);
        checkOutput("monitor_block", recon, blk);
        checkOutput("done_at_end", done, 1);
        checkOutput("ready_at_end", block_ready, 1);
        checkOutput("txd_at_end", txd, 1);
        if (!keep_valid) block_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] known;
        logic [127:0] blk;
        int           idle_bad;
        int           first_accept;

        checks = 0;
        errors = 0;
        last_accept = 0;
        known = 128'h00112233445566778899AABBCCDDEEFF;

        tbl[0] = '{0,  10'b0_00000000_1};
        tbl[1] = '{1,  10'b0_10001000_1};
        tbl[2] = '{4,  10'b0_00100010_1};
        tbl[3] = '{10, 10'b0_01010101_1};
        tbl[4] = '{15, 10'b0_11111111_1};

        reset       = 1'b1;
        block_valid = 1'b0;
        block_in    = '0;
        repeat (3) tick();
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_ready", block_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_txd", txd, 1);
        checkOutput("post_reset_ready", block_ready, 1);
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (txd !== 1'b1 || block_ready !== 1'b1 || done !== 1'b0) idle_bad++;
            tick();
        end
        checkOutput("idle_1000_cycles", idle_bad, 0);

        applyStimulus(known, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("frame_byte%0d", tbl[i].byte_n), cap_frames[tbl[i].byte_n], tbl[i].frame);
        end
        tick();

        applyStimulus(known, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("isolated_frame_byte%0d", tbl[i].byte_n), cap_frames[tbl[i].byte_n], tbl[i].frame);
        end
        tick();

        applyStimulus({16{8'hA5}}, 1'b0, 1'b1);
        first_accept = last_accept;
        applyStimulus({16{8'h5A}}, 1'b0, 1'b0);
        checkOutput("back_to_back_gap", last_accept - first_accept, BLOCK_CYC + 1);
        tick();

        blk = {$urandom, $urandom, $urandom, $urandom};
        blk[83] = 1'b0;
        block_in    = blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        repeat ((5 * 10 + 4) * CPB + 2) tick();
        checkOutput("midblock_txd_before_reset", txd, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_txd", txd, 1);
        checkOutput("async_reset_ready", block_ready, 1);
        checkOutput("async_reset_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("after_abort_ready", block_ready, 1);
        checkOutput("after_abort_done", done, 0);
        checkOutput("after_abort_txd", txd, 1);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(1, 3)) tick();
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
